// File: rtl/sb_tx_msg_arbiter.sv
// rtl/sb_tx_msg_arbiter.sv - round-robin arbiter sharing the sideband TX message path
// Grants one requester at a time, waits for the transmitter ack or a watchdog expiry.
module sb_tx_msg_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 1024,
    parameter int MSG_W       = 64
) (
    input  logic                       clk_100MHz,
    input  logic                       reset,
    input  logic                       enable_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*MSG_W-1:0]   req_msg_i,
    output logic [NUM_REQ-1:0]         req_ack_o,
    output logic [NUM_REQ-1:0]         req_err_o,
    output logic [MSG_W-1:0]           TX_msg_o,
    output logic                       TX_msg_valid_o,
    input  logic                       TX_msg_valid_ack_i,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o,
    output logic                       timeout_o
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   last_grant_q;
    logic [ID_W-1:0]   pick;
    logic [ID_W-1:0]   idx;
    logic              pick_found;
    logic [CNT_W-1:0]  wd_cnt_q;
    logic              wd_expire;
    logic              grant_en;

    assign wd_expire      = (ACK_TIMEOUT != 0) && (wd_cnt_q == WD_LAST);
    assign grant_en       = enable_i && (req_valid_i != '0);
    assign TX_msg_valid_o = (state_q == ST_SEND);
    assign busy_o         = (state_q != ST_IDLE);

    // Search starts just above the last completed grant and wraps around.
    always_comb begin
        pick_found = 1'b0;
        pick       = last_grant_q;
        idx        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(last_grant_q) + i) % NUM_REQ);
            if (!pick_found && req_valid_i[idx]) begin
                pick_found = 1'b1;
                pick       = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (TX_msg_valid_ack_i || wd_expire) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            TX_msg_o     <= '0;
            grant_id_o   <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            wd_cnt_q     <= '0;
            req_ack_o    <= '0;
            req_err_o    <= '0;
            timeout_o    <= 1'b0;
        end else begin
            req_ack_o <= '0;
            req_err_o <= '0;
            timeout_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_en) begin
                        TX_msg_o   <= req_msg_i[int'(pick)*MSG_W +: MSG_W];
                        grant_id_o <= pick;
                        wd_cnt_q   <= '0;
                    end
                end
                ST_SEND: begin
                    // Ack takes priority over a same-cycle watchdog expiry.
                    if (TX_msg_valid_ack_i) begin
                        req_ack_o[grant_id_o] <= 1'b1;
                        last_grant_q          <= grant_id_o;
                    end else if (wd_expire) begin
                        req_err_o[grant_id_o] <= 1'b1;
                        timeout_o             <= 1'b1;
                        last_grant_q          <= grant_id_o;
                    end else if (ACK_TIMEOUT != 0) begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
